// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the integer register-file write port: picks one of
// LSU/DIV/ALU per cycle (starvation-promoted fixed priority) and registers the write.
module reg_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            div_valid,
  input  logic [4:0]      div_rd,
  input  logic [XLEN-1:0] div_data,
  output logic            div_ready,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [1:0]      grant_id
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      wait_lsu, wait_div, wait_alu;
  logic [2:0]      valid_vec, promoted, grant;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [1:0]      sel_id;
  logic            we_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      gid_q;

  function automatic logic [2:0] pick_first(input logic [2:0] m);
    if (m[0])      return 3'b001;
    else if (m[1]) return 3'b010;
    else if (m[2]) return 3'b100;
    else           return 3'b000;
  endfunction

  function automatic logic [3:0] next_wait(input logic [3:0] cnt, input logic v,
                                           input logic g, input logic h);
    if (!v || g)         return 4'd0;
    else if (h)          return cnt;
    else if (cnt < LIMIT) return cnt + 4'd1;
    else                 return cnt;
  endfunction

  assign valid_vec = {alu_valid, div_valid, lsu_valid};
  assign promoted  = valid_vec & {wait_alu == LIMIT, wait_div == LIMIT, wait_lsu == LIMIT};

  // Promoted requesters take precedence; base order LSU > DIV > ALU breaks ties.
  always_comb begin
    grant = 3'b000;
    if (!rst && !hold) begin
      if (|promoted) grant = pick_first(promoted);
      else           grant = pick_first(valid_vec);
    end
  end

  assign lsu_ready = grant[0];
  assign div_ready = grant[1];
  assign alu_ready = grant[2];

  always_comb begin
    sel_rd   = 5'd0;
    sel_data = '0;
    sel_id   = 2'd0;
    if (grant[0]) begin
      sel_rd = lsu_rd; sel_data = lsu_data; sel_id = 2'd1;
    end else if (grant[1]) begin
      sel_rd = div_rd; sel_data = div_data; sel_id = 2'd2;
    end else if (grant[2]) begin
      sel_rd = alu_rd; sel_data = alu_data; sel_id = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_lsu <= 4'd0;
      wait_div <= 4'd0;
      wait_alu <= 4'd0;
    end else begin
      wait_lsu <= next_wait(wait_lsu, lsu_valid, grant[0], hold);
      wait_div <= next_wait(wait_div, div_valid, grant[1], hold);
      wait_alu <= next_wait(wait_alu, alu_valid, grant[2], hold);
    end
  end

  // A write to x0 still completes the handshake and reports its source, but leaves addr/data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      gid_q   <= 2'd0;
    end else if (|grant) begin
      gid_q <= sel_id;
      we_q  <= (sel_rd != 5'd0);
      if (sel_rd != 5'd0) begin
        waddr_q <= sel_rd;
        wdata_q <= sel_data;
      end
    end else begin
      we_q  <= 1'b0;
      gid_q <= 2'd0;
    end
  end

  // Reset masks the registered write immediately so a write registered just before reset is dropped.
  assign rf_we    = we_q & ~rst;
  assign rf_waddr = rst ? 5'd0 : waddr_q;
  assign rf_wdata = rst ? '0 : wdata_q;
  assign grant_id = rst ? 2'd0 : gid_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural arbitration model.
module tb_reg_wb_arbiter;

  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic [2:0] v;
  logic [2:0][4:0] rd;
  logic [2:0][XLEN-1:0] d;
  logic [2:0] rdy;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [1:0] grant_id;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state: waiting cycles per requester and the expected write register.
  int wait_m [3] = '{0, 0, 0};
  logic exp_we = 1'b0;
  logic [4:0] exp_waddr = 5'd0;
  logic [XLEN-1:0] exp_wdata = '0;
  logic [1:0] exp_gid = 2'd0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .lsu_valid(v[0]), .lsu_rd(rd[0]), .lsu_data(d[0]), .lsu_ready(rdy[0]),
    .div_valid(v[1]), .div_rd(rd[1]), .div_data(d[1]), .div_ready(rdy[1]),
    .alu_valid(v[2]), .alu_rd(rd[2]), .alu_data(d[2]), .alu_ready(rdy[2]),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id)
  );

  // Winner is 1..3 (LSU, DIV, ALU) or 0: starved requesters first, otherwise index order.
  function automatic int model_grant();
    int g = 0;
    if (rst || hold) return 0;
    for (int i = 0; i < 3; i++)
      if (g == 0 && v[i] && wait_m[i] == LIMIT) g = i + 1;
    for (int i = 0; i < 3; i++)
      if (g == 0 && v[i]) g = i + 1;
    return g;
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] r = 3'b000;
    if (g != 0) r[g-1] = 1'b1;
    return r;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      for (int i = 0; i < 3; i++) wait_m[i] = 0;
      exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = '0; exp_gid = 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || g == i + 1) wait_m[i] = 0;
        else if (!hold && wait_m[i] < LIMIT) wait_m[i] = wait_m[i] + 1;
      end
      if (g != 0) begin
        exp_gid = 2'(g);
        exp_we  = (rd[g-1] != 5'd0);
        if (rd[g-1] != 5'd0) begin
          exp_waddr = rd[g-1];
          exp_wdata = d[g-1];
        end
      end else begin
        exp_we = 1'b0; exp_gid = 2'd0;
      end
    end
  endtask

  task automatic advance(output int g);
    g = model_grant();
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; hold = 1'b0; v = 3'b111;
    rd = '0; d = '0;
    #2;
    compared++;
    if (rdy !== 3'b000) begin
      mismatched++; $display("[TB] FAIL reset_ready got %b want 000", rdy);
    end
    advance(g);
    compared++;
    if ({rf_we, rf_waddr, rf_wdata, grant_id} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got we=%b addr=%0d data=%h id=%0d want all zero",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
    rst = 1'b0; v = 3'b000;
    advance(g);
  endtask

  task automatic test_single_alu();
    int g;
    v = 3'b100; rd[2] = 5'd5; d[2] = 64'h1234;
    #2;
    compared++;
    if (rdy !== 3'b100) begin
      mismatched++; $display("[TB] FAIL alu_ready got %b want 100", rdy);
    end
    advance(g);
    v = 3'b000;
    compared++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234 || grant_id !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL alu_write got we=%b addr=%0d data=%h id=%0d want 1/5/1234/3",
               rf_we, rf_waddr, rf_wdata, grant_id);
    end
  endtask

  task automatic test_collision();
    int g;
    v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 5'(i + 1); d[i] = 64'hA000 + 64'(i);
    end
    for (int k = 0; k < 3; k++) begin
      #2;
      compared++;
      if (rdy !== onehot(k + 1)) begin
        mismatched++; $display("[TB] FAIL collision_ready[%0d] got %b want %b", k, rdy, onehot(k + 1));
      end
      advance(g);
      v[k] = 1'b0;
      compared++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(k + 1) || grant_id !== 2'(k + 1)) begin
        mismatched++;
        $display("[TB] FAIL collision_write[%0d] got we=%b addr=%0d id=%0d want 1/%0d/%0d",
                 k, rf_we, rf_waddr, grant_id, k + 1, k + 1);
      end
    end
  endtask

  task automatic test_starvation();
    int g;
    v = 3'b101; rd[2] = 5'd20; d[2] = 64'hA1A1;
    for (int c = 0; c < 8; c++) begin
      rd[0] = 5'(c + 1); d[0] = {32'h0, $urandom};
      #2;
      compared++;
      if (rdy !== (c == 4 ? 3'b100 : 3'b001)) begin
        mismatched++; $display("[TB] FAIL starve_ready[c%0d] got %b", c, rdy);
      end
      advance(g);
      compared++;
      if (grant_id !== (c == 4 ? 2'd3 : 2'd1)) begin
        mismatched++; $display("[TB] FAIL starve_grant[c%0d] got %0d want %0d", c, grant_id, c == 4 ? 3 : 1);
      end
      if (c == 4) v[2] = 1'b0;
    end
    v = 3'b000;
    advance(g);
  endtask

  task automatic test_x0();
    int g;
    logic [4:0] prev_addr;
    logic [XLEN-1:0] prev_data;
    prev_addr = exp_waddr; prev_data = exp_wdata;
    v = 3'b010; rd[1] = 5'd0; d[1] = '1;
    #2;
    compared++;
    if (rdy !== 3'b010) begin
      mismatched++; $display("[TB] FAIL x0_ready got %b want 010", rdy);
    end
    advance(g);
    v = 3'b000;
    compared++;
    if (rf_we !== 1'b0 || grant_id !== 2'd2 || rf_waddr !== prev_addr || rf_wdata !== prev_data) begin
      mismatched++;
      $display("[TB] FAIL x0_write got we=%b id=%0d addr=%0d data=%h want 0/2/%0d/%h",
               rf_we, grant_id, rf_waddr, rf_wdata, prev_addr, prev_data);
    end
  endtask

  task automatic test_hold();
    int g;
    advance(g);
    v = 3'b111; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 5'(10 + i); d[i] = 64'hB0 + 64'(i);
    end
    for (int c = 0; c < 3; c++) begin
      #2;
      compared++;
      if (rdy !== 3'b000) begin
        mismatched++; $display("[TB] FAIL hold_ready[c%0d] got %b want 000", c, rdy);
      end
      advance(g);
      compared++;
      if (rf_we !== 1'b0 || grant_id !== 2'd0) begin
        mismatched++; $display("[TB] FAIL hold_write[c%0d] got we=%b id=%0d want 0/0", c, rf_we, grant_id);
      end
    end
    hold = 1'b0;
    #2;
    compared++;
    if (rdy !== 3'b001) begin
      mismatched++; $display("[TB] FAIL hold_release got %b want 001", rdy);
    end
    advance(g);
    v = 3'b000;
    advance(g);
  endtask

  task automatic test_reset_midstream();
    int g;
    v = 3'b100; rd[2] = 5'd9; d[2] = 64'hCAFE;
    advance(g);
    rst = 1'b1; v = 3'b111;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 5'(i + 3); d[i] = 64'hD0 + 64'(i);
    end
    #2;
    compared++;
    if (rdy !== 3'b000 || rf_we !== 1'b0 || grant_id !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset got rdy=%b we=%b id=%0d want 000/0/0", rdy, rf_we, grant_id);
    end
    advance(g);
    rst = 1'b0;
    #2;
    compared++;
    if (rdy !== 3'b001) begin
      mismatched++; $display("[TB] FAIL post_reset_ready got %b want 001", rdy);
    end
    advance(g);
    compared++;
    if (grant_id !== 2'd1 || rf_waddr !== 5'd3) begin
      mismatched++; $display("[TB] FAIL post_reset_write got id=%0d addr=%0d want 1/3", grant_id, rf_waddr);
    end
    v = 3'b000;
    advance(g);
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && ($urandom % 3 != 0)) begin
          v[i] = 1'b1;
          rd[i] = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
          d[i] = {$urandom, $urandom};
        end
      end
      hold = ($urandom % 8 == 0);
      #2;
      compared++;
      if (rdy !== onehot(model_grant())) begin
        mismatched++; $display("[TB] FAIL rand_ready[c%0d] got %b want %b", c, rdy, onehot(model_grant()));
      end
      advance(g);
      compared++;
      if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata || grant_id !== exp_gid) begin
        mismatched++;
        $display("[TB] FAIL rand_write[c%0d] got %b/%0d/%h/%0d want %b/%0d/%h/%0d", c,
                 rf_we, rf_waddr, rf_wdata, grant_id, exp_we, exp_waddr, exp_wdata, exp_gid);
      end
      if (g != 0) v[g-1] = 1'b0;
    end
    hold = 1'b0; v = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_starvation();
    test_x0();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter for the single integer register-file write port. It sits between the three result producers (load unit, multi-cycle divider, single-cycle ALU path) and the register file. Each cycle it grants at most one producer through a valid/ready handshake. The accepted result is registered and driven onto `rf_we`/`rf_waddr`/`rf_wdata` one cycle later. Fixed priority is tempered by per-requester starvation counters, so the divider and the ALU path cannot be locked out by back-to-back loads.

## Interface
Parameters:
- `XLEN`, 64, data width of every result and of the write port.
- `STARVE_LIMIT`, 4, number of consecutive waiting cycles after which a requester is promoted; range 1..15.

Ports:
- Clock and reset: one clock, `clk`; reset `rst`, synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `hold`  in  1  when high, no grant is issued; debug/halt freeze.
- `lsu_valid`  in  1  load result pending.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  XLEN  load result, already sign/zero extended.
- `lsu_ready`  out  1  load result accepted this cycle.
- `div_valid`, `div_rd`, `div_data`, `div_ready`  same widths and directions; divider/remainder result.
- `alu_valid`, `alu_rd`, `alu_data`, `alu_ready`  same widths and directions; ALU/immediate/PC-link result.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_waddr`  out  5  write address (registered).
- `rf_wdata`  out  XLEN  write data (registered).
- `grant_id`  out  2  source of the current `rf_*` write: 0 none, 1 LSU, 2 DIV, 3 ALU (registered).

## Operation
- Handshake: a transfer occurs when `x_valid & x_ready`.
  - Requesters hold valid, rd and data stable until ready.
  - `x_ready` is combinational from valids, counters, `hold` and `rst`.
  - Requesters must not wait for ready before raising valid.
- At most one `x_ready` is high per cycle, only toward a valid requester. No valid requester means no ready.
- Base priority: LSU > DIV > ALU.
- Starvation counters `wait_lsu`, `wait_div`, `wait_alu`, each 4 bits:
  - Increment by 1 each cycle the requester is valid, not granted and `hold` is low.
  - Saturate at `STARVE_LIMIT`.
  - Clear to 0 on grant, or in any cycle the requester's valid is low.
  - Unchanged while `hold` is high and valid stays high.
- Promotion: a requester whose counter equals `STARVE_LIMIT` is promoted.
  - Any promoted requester beats every non-promoted one.
  - Among several promoted requesters, base priority applies.
- `hold` high: every ready is 0 and no new write is issued. The write registered in the previous cycle still completes.
- Write register, updated every cycle:
  - Transfer accepted with rd ≠ 0: next cycle `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=data, `grant_id`=source.
  - Transfer accepted with rd = 0: the handshake completes. Next cycle `rf_we`=0 and `grant_id`=source; `rf_waddr`/`rf_wdata` keep their previous values.
  - No transfer: next cycle `rf_we`=0 and `grant_id`=0; `rf_waddr`/`rf_wdata` hold.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `grant_id`=0, all counters 0.
- All ready outputs are forced to 0 in any cycle `rst` is high, so nothing is accepted during reset.
- Reset asserted mid-stream:
  - A write registered in cycle N−1 is discarded if `rst` is high in cycle N, because outputs take reset values.
  - Pending requesters must re-present after reset.
- Latency: handshake in cycle N, then `rf_we` high in cycle N+1 and the register file captures the value at the end of N+1.
- Throughput: one write per cycle, with no bubble between consecutive grants.
- Worst-case wait: a continuously valid requester is granted within `STARVE_LIMIT`+2 cycles of raising valid, with `hold` low throughout.
- Requester waits on `rd` hazards are outside this block; forwarding/scoreboard logic observes `rf_*` and `grant_id`.

## Test plan
- Single ALU write: `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 → `alu_ready`=1 in the same cycle; next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `grant_id`=3.
- Three-way collision: LSU rd=1, DIV rd=2 and ALU rd=3 all valid in the same cycle, each dropping valid after its grant → grants LSU, DIV, ALU on consecutive cycles; `rf_waddr` sequence 1, 2, 3 with `rf_we`=1 on three consecutive cycles.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: LSU valid continuously with new data each cycle; ALU valid from cycle 0.
  - Response: ALU is granted in cycle 4, the first cycle `wait_alu`=4; LSU is granted in cycles 0-3 and 5 onward.
- Write to x0: DIV valid with rd=0, data=0xFFFFFFFFFFFFFFFF → `div_ready`=1; next cycle `rf_we`=0, `grant_id`=2, `rf_waddr`/`rf_wdata` unchanged.
- Hold: all three requesters valid with `hold`=1 for 3 cycles → all readies 0, `rf_we`=0, counters frozen at 0. After `hold` drops, LSU is granted in the first cycle.
- Reset mid-stream: ALU granted in cycle N, `rst`=1 in cycle N+1 → `rf_we`=0 and `grant_id`=0 in N+1, all readies 0 while `rst` is high. After `rst` deasserts, the first grant follows base priority.
